parity_link_pipe: RTL and testbench

- Registered single-lane parity link: sender → fault-injecting channel → receiver.
- Sender appends an even-parity bit to an 8-bit byte, giving a 9-bit word. The channel optionally corrupts that word with a KEY-selected bit flip. The receiver flags any parity mismatch.
- Used as a self-checking link model and error-statistics source in the data-integrity test subsystem.

---
 rtl/parity_link_pkg.sv | 20 ++
 rtl/parity_link_pipe_parity_gen_chk.sv | 15 +
 rtl/parity_link_pipe.sv | 108 ++++++++++
 tb/tb_parity_link_pipe.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_link_pkg.sv
// Shared widths and helper functions for the parity link pipeline.
package parity_link_pkg;

  localparam int DATA_W = 8;
  localparam int WORD_W = 9;

  // Parity over a word-wide vector; narrower data is zero-extended by the caller.
  function automatic logic parity_of(input logic [WORD_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  // Single-bit corruption mask selected by key; key 0 means a transparent channel.
  function automatic logic [WORD_W-1:0] key_mask(input int key, input logic en);
    logic [WORD_W-1:0] m;
    m = '0;
    if (en && key != 0) m = WORD_W'(1) << key;
    return m;
  endfunction

endpackage

// File: rtl/parity_link_pipe_parity_gen_chk.sv
// Combinational parity generator/checker. As a generator it is fed the data
// byte; as a checker it is fed the full word and a 1 means a parity failure.
module parity_gen_chk
  import parity_link_pkg::*;
#(
  parameter int W   = DATA_W,
  parameter bit ODD = 1'b0
) (
  input  logic [W-1:0] bits,
  output logic         parity
);

  assign parity = parity_of(WORD_W'(bits), ODD);

endmodule

// File: rtl/parity_link_pipe.sv
// Two-stage parity link: sender register, KEY-selected fault channel,
// receiver register with parity check, plus saturating word/error counters.
// Optional capture of the first erroring word: define PARITY_LINK_ERRLOG_EN.
module parity_link_pipe
  import parity_link_pkg::*;
#(
  parameter int KEY        = 2,
  parameter int CNT_W      = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              inject_en,
  input  logic              clr_counts,
  output logic [8:0]        tx_word,
  output logic              tx_valid,
  output logic [8:0]        rx_word,
  output logic              error_check,
  output logic              out_valid,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  error_count
`ifdef PARITY_LINK_ERRLOG_EN
  ,
  output logic [8:0]        first_err_word,
  output logic              err_seen
`endif
);

  if (KEY < 0 || KEY > 7) begin : g_bad_key
    $fatal(1, "parity_link_pipe: KEY must be in 0..7");
  end

  logic             tx_par;
  logic [WORD_W-1:0] chan_word;
  logic             chan_err;

  parity_gen_chk #(.W(DATA_W), .ODD(PARITY_ODD)) u_gen (
    .bits   (in_data),
    .parity (tx_par)
  );

  // inject_en is applied to the word while it sits in stage 1
  assign chan_word = tx_word ^ key_mask(KEY, inject_en);

  parity_gen_chk #(.W(WORD_W), .ODD(PARITY_ODD)) u_chk (
    .bits   (chan_word),
    .parity (chan_err)
  );

  // Sender stage: capture byte plus parity, hold word when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_word  <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= in_valid;
      if (in_valid) tx_word <= {in_data, tx_par};
    end
  end

  // Receiver stage: register the post-channel word and its check result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_word     <= '0;
      error_check <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= tx_valid;
      if (tx_valid) begin
        rx_word     <= chan_word;
        error_check <= chan_err;
      end
    end
  end

  // Saturating statistics; a clear takes priority over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count  <= '0;
      error_count <= '0;
    end else if (clr_counts) begin
      word_count  <= '0;
      error_count <= '0;
    end else if (out_valid) begin
      if (word_count != '1) word_count <= word_count + CNT_W'(1);
      if (error_check && error_count != '1) error_count <= error_count + CNT_W'(1);
    end
  end

`ifdef PARITY_LINK_ERRLOG_EN
  // Sticky capture of the first failing word since reset or clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_word <= '0;
      err_seen       <= 1'b0;
    end else if (clr_counts) begin
      first_err_word <= '0;
      err_seen       <= 1'b0;
    end else if (out_valid && error_check && !err_seen) begin
      first_err_word <= rx_word;
      err_seen       <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_parity_link_pipe.sv
// Scoreboard bench for parity_link_pipe: three instances with different
// KEY / CNT_W / PARITY_ODD share one stimulus stream; a reference model
// pushes expected words per instance and a negedge monitor checks them.
module tb_parity_link_pipe;

  localparam int NDUT = 3;
  localparam int KEYS [NDUT] = '{2, 7, 0};
  localparam int CWS  [NDUT] = '{16, 4, 16};
  localparam bit ODDS [NDUT] = '{1'b0, 1'b0, 1'b1};

  typedef struct packed {
    logic [8:0] rx;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       inject_en = 1'b0;
  logic       clr_counts = 1'b0;

  logic [8:0]  tx_w  [NDUT];
  logic        txv_w [NDUT];
  logic [8:0]  rx_w  [NDUT];
  logic        err_w [NDUT];
  logic        ov_w  [NDUT];
  logic [15:0] wc_w  [NDUT];
  logic [15:0] ec_w  [NDUT];
`ifdef PARITY_LINK_ERRLOG_EN
  logic [8:0]  few_w [NDUT];
  logic        seen_w[NDUT];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int K  = KEYS[g];
    localparam int CW = CWS[g];
    localparam bit OD = ODDS[g];
    logic [CW-1:0] wc, ec;
    logic [8:0] txw, rxw;
    logic txv, errc, ov;
`ifdef PARITY_LINK_ERRLOG_EN
    logic [8:0] few;
    logic seen;
`endif
    parity_link_pipe #(.KEY(K), .CNT_W(CW), .PARITY_ODD(OD)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .inject_en   (inject_en),
      .clr_counts  (clr_counts),
      .tx_word     (txw),
      .tx_valid    (txv),
      .rx_word     (rxw),
      .error_check (errc),
      .out_valid   (ov),
      .word_count  (wc),
      .error_count (ec)
`ifdef PARITY_LINK_ERRLOG_EN
      ,
      .first_err_word (few),
      .err_seen       (seen)
`endif
    );
    assign tx_w[g]  = txw;
    assign txv_w[g] = txv;
    assign rx_w[g]  = rxw;
    assign err_w[g] = errc;
    assign ov_w[g]  = ov;
    assign wc_w[g]  = 16'(wc);
    assign ec_w[g]  = 16'(ec);
`ifdef PARITY_LINK_ERRLOG_EN
    assign few_w[g]  = few;
    assign seen_w[g] = seen;
`endif
  end

  int total = 0;
  int bad   = 0;

  logic [8:0] txq [NDUT][$];
  exp_t       rxq [NDUT][$];
  int         exp_wc [NDUT];
  int         exp_ec [NDUT];
`ifdef PARITY_LINK_ERRLOG_EN
  logic [8:0] exp_few [NDUT];
  logic       exp_seen[NDUT];
`endif
  logic pend_inj = 1'b0;

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, g, act, want, $time);
    end
  endtask

  // Reference model: parity by population count, corruption as a bit flip
  task automatic push_expect(input logic [7:0] d, input logic inj);
    for (int g = 0; g < NDUT; g++) begin
      logic [8:0] tx, rx;
      exp_t e;
      tx = {d, logic'(($countones(d) % 2) == 1) ^ ODDS[g]};
      rx = tx;
      if (inj && KEYS[g] != 0) rx[KEYS[g]] = ~rx[KEYS[g]];
      e.rx  = rx;
      e.err = logic'(($countones(rx) % 2) == 1) ^ ODDS[g];
      txq[g].push_back(tx);
      rxq[g].push_back(e);
    end
  endtask

  // One cycle of stimulus; inject_en for a word is presented one cycle after it
  task automatic step(input logic v, input logic [7:0] d, input logic inj, input logic clr);
    @(posedge clk);
    #1;
    in_valid   = v;
    in_data    = d;
    inject_en  = v ? pend_inj : logic'($urandom_range(0, 1));
    if (!v) inject_en = pend_inj;
    pend_inj   = v ? inj : logic'($urandom_range(0, 1));
    clr_counts = clr;
    if (v) push_expect(d, inj);
  endtask

  task automatic clear_model();
    for (int g = 0; g < NDUT; g++) begin
      txq[g].delete();
      rxq[g].delete();
      exp_wc[g] = 0;
      exp_ec[g] = 0;
`ifdef PARITY_LINK_ERRLOG_EN
      exp_few[g]  = '0;
      exp_seen[g] = 1'b0;
`endif
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int g = 0; g < NDUT; g++)
      check(name, g, {tx_w[g], txv_w[g], rx_w[g], err_w[g], ov_w[g], wc_w[g] | ec_w[g]}, 32'h0);
  endtask

  // Monitor: check outputs on the falling edge, then advance the counter model
  always @(negedge clk) begin
    if (rst) begin
      clear_model();
    end else begin
      for (int g = 0; g < NDUT; g++) begin
        exp_t e;
        logic e_ok;
        e = '0;
        e_ok = 1'b0;
        if (txv_w[g]) begin
          if (txq[g].size() == 0) check("unexpected_tx_valid", g, 32'd1, 32'd0);
          else check("tx_word", g, 32'(tx_w[g]), 32'(txq[g].pop_front()));
        end
        if (ov_w[g]) begin
          if (rxq[g].size() == 0) check("unexpected_out_valid", g, 32'd1, 32'd0);
          else begin
            e = rxq[g].pop_front();
            e_ok = 1'b1;
            check("rx_word", g, 32'(rx_w[g]), 32'(e.rx));
            check("error_check", g, 32'(err_w[g]), 32'(e.err));
          end
        end
        check("word_count", g, 32'(wc_w[g]), 32'(exp_wc[g]));
        check("error_count", g, 32'(ec_w[g]), 32'(exp_ec[g]));
`ifdef PARITY_LINK_ERRLOG_EN
        check("err_seen", g, 32'(seen_w[g]), 32'(exp_seen[g]));
        check("first_err_word", g, 32'(few_w[g]), 32'(exp_few[g]));
`endif
        if (clr_counts) begin
          exp_wc[g] = 0;
          exp_ec[g] = 0;
`ifdef PARITY_LINK_ERRLOG_EN
          exp_few[g]  = '0;
          exp_seen[g] = 1'b0;
`endif
        end else if (e_ok) begin
          if (exp_wc[g] < (1 << CWS[g]) - 1) exp_wc[g]++;
          if (e.err && exp_ec[g] < (1 << CWS[g]) - 1) exp_ec[g]++;
`ifdef PARITY_LINK_ERRLOG_EN
          if (e.err && !exp_seen[g]) begin
            exp_seen[g] = 1'b1;
            exp_few[g]  = e.rx;
          end
`endif
        end
      end
    end
  end

  initial begin
    clear_model();
    #2;
    check_all_zero("reset_state");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Encode A5 on a clean channel
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("enc_tx_a5", 0, 32'(tx_w[0]), 32'h14A);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("enc_rx_a5", 0, 32'(rx_w[0]), 32'h14A);
    check("enc_err_a5", 0, 32'(err_w[0]), 32'h0);
    check("enc_ov_a5", 0, 32'(ov_w[0]), 32'h1);

    // Odd-weight byte
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("enc_tx_01", 0, 32'(tx_w[0]), 32'h003);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("enc_err_01", 0, 32'(err_w[0]), 32'h0);

    // Injection with KEY=2
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("inj_rx_a5", 0, 32'(rx_w[0]), 32'h14E);
    check("inj_err_a5", 0, 32'(err_w[0]), 32'h1);

    // Ten consecutive injected words after a clear
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("ten_word_count", 0, 32'(wc_w[0]), 32'd10);
    check("ten_error_count", 0, 32'(ec_w[0]), 32'd10);
    check("ten_transparent_errs", 2, 32'(ec_w[2]), 32'd0);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step(logic'($urandom_range(0, 3) != 0), 8'($urandom), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 31) == 0));

    // Saturation then clear coinciding with out_valid
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("sat_word_count", 1, 32'(wc_w[1]), 32'd15);
    check("sat_error_count", 1, 32'(ec_w[1]), 32'd15);
    check("clr_needs_ov", 1, 32'(ov_w[1]), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("clr_word_count", 1, 32'(wc_w[1]), 32'd0);
    check("clr_error_count", 1, 32'(ec_w[1]), 32'd0);
    check("clr_word_count", 0, 32'(wc_w[0]), 32'd0);

    // Reset with two words in flight
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    step(1'b1, 8'hC7, 1'b1, 1'b0);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    pend_inj = 1'b0;
    #1;
    check_all_zero("midstream_reset");
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int g = 0; g < NDUT; g++) check("post_reset_idle_ov", g, 32'(ov_w[g]), 32'd0);

    // Resume traffic after reset
    for (int i = 0; i < 40; i++)
      step(logic'($urandom_range(0, 1)), 8'($urandom), logic'($urandom_range(0, 1)), 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int g = 0; g < NDUT; g++) begin
      check("drain_tx_queue", g, 32'(txq[g].size()), 32'd0);
      check("drain_rx_queue", g, 32'(rxq[g].size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
